belief_update: RTL
==================

Name: belief_update

Overview:
Bayesian belief updater for the 2-state POMDP. It is the consumer side of the transition/observation sampler: given prior b(s=0), an action and a received observation, it computes the posterior b'(s'=0).
- It uses the same trans table format, where trans[a][s][0] = P(s'=0 | s, a) in Q0.16.
- It also takes a per-action observation table.
- Output feeds the PBVI value-lookup stage.
- Multi-cycle: predict, correct, then normalise with an iterative fractional divider.

Parameters:
PW, 16, probability width (Q0.PW); ONE = all-ones (2^PW-1) represents 1.0
NUM_ACT, 3, number of actions; legal action codes 0..NUM_ACT-1

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  request valid
in_ready  out  1  high only in IDLE
action  in  2  action code
obs  in  1  observed symbol
belief_in  in  PW  prior b(s=0); b(s=1) = ONE - belief_in
trans  in  PW x [NUM_ACT][2][2]  trans[a][s][0] = P(s'=0|s,a); index [1] unused; P(s'=1) = ONE - [0]
obs_prob  in  PW x [NUM_ACT][2]  obs_prob[a][s'] = P(o=0|s',a); P(o=1) = ONE - value
out_valid  out  1  result valid, held until out_ready
out_ready  in  1  consumer accepts
belief_out  out  PW  posterior b'(s'=0)
err  out  1  degenerate update (zero evidence or illegal action); valid with out_valid

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, in_ready=1, out_valid=0, belief_out=0, err=0, datapath regs cleared. Reset mid-operation aborts the update; no output is produced.
- Accept: in_valid & in_ready at edge k. Registers action, obs, belief_in, and the trans/obs_prob rows for that action. These inputs are ignored afterwards.
- States: IDLE -> PRED -> CORR -> NORM -> DIV -> DONE -> IDLE.
- PRED (1 cycle): pred0 = (b0*T[a][0][0] + b1*T[a][1][0]) >> PW, using full-width sum then truncate. pred1 = ONE - pred0.
- CORR (1 cycle):
  - O0 = obs ? ONE-obs_prob[a][0] : obs_prob[a][0]; O1 likewise for s'=1.
  - u0 = (pred0*O0)>>PW; u1 = (pred1*O1)>>PW, truncated.
  - sum = u0+u1 (PW+1 bits).
- NORM (1 cycle):
  - Illegal action (>= NUM_ACT) or sum==0: belief_out = registered belief_in, err=1 -> DONE.
  - Else u1==0: belief_out = ONE, err=0 -> DONE.
  - Else: load divider -> DIV.
- DIV: restoring division, quotient = floor((u0<<PW)/sum). u0<sum, so the quotient fits in PW bits; one bit per cycle, PW cycles. err=0 -> DONE.
- DONE: out_valid=1, belief_out/err stable until out_ready. On out_ready -> IDLE; in_ready rises the next cycle. No skid; new requests are never accepted while busy.
- Latency (accept edge k to out_valid high):
  - Normal path: out_valid high after edge k+3+PW (k+19 at PW=16).
  - Degenerate/saturate path: out_valid high after edge k+3.
- Back-to-back: next accept earliest one cycle after the out_ready handshake.
- in_valid while busy: ignored (in_ready=0); the requester must hold it.

Decomposition:
- pomdp_pkg holds:
  - prob_t (logic [PW-1:0]), action_t (logic [1:0])
  - PROB_ONE constant
  - bu_state_e enum {IDLE,PRED,CORR,NORM,DIV,DONE}
  - trans/obs table typedefs shared with the sampler
- One sub-module: frac_div (PW-bit restoring fractional divider; start/busy/done; quotient = floor((a<<PW)/b), requires a<b).

Test Plan:
1. a=0, T[0][0][0]=T[0][1][0]=0x8000, b0=0x8000, obs_prob[0]={0xC000,0x4000}, obs=0 -> pred0=0x7FFF, u0=0x5FFF, u1=0x2000, belief_out=0xBFFF, err=0, out_valid 19 cycles after accept.
2. Same as 1 but obs=1 -> O0=0x3FFF, O1=0xBFFF; check belief_out against the golden model (truncating arithmetic), err=0.
3. obs_prob[a]={0,0}, obs=0, b0=0x1234 -> belief_out=0x1234, err=1, latency 3.
4. obs_prob[a]={0xFFFF,0}, obs=0, T[a][*][0]=0x8000 -> u1=0, belief_out=0xFFFF, err=0, latency 3.
5. action=3, b0=0x4000 -> belief_out=0x4000, err=1, latency 3; then out_ready held low 5 cycles -> out_valid/belief_out stable, in_ready=0, in_valid pulses ignored.
6. Reset asserted during DIV (cycle 10) -> outputs reset immediately; after release in_ready=1, out_valid=0; the next request (scenario 1 values) gives 0xBFFF.

Source files
------------

// File: rtl/pomdp_pkg.sv
// Shared types and constants for the 2-state POMDP blocks (sampler and belief updater).
package pomdp_pkg;

  localparam int PROB_W      = 16;
  localparam int NUM_ACTIONS = 3;

  typedef logic [PROB_W-1:0] prob_t;
  typedef logic [1:0]        action_t;

  localparam prob_t PROB_ONE = '1;

  typedef enum logic [2:0] {
    IDLE,
    PRED,
    CORR,
    NORM,
    DIV,
    DONE
  } bu_state_e;

  // trans_tbl_t[a][s][0] = P(s'=0 | s, a); obs_tbl_t[a][s'] = P(o=0 | s', a)
  typedef prob_t [1:0][1:0]  trans_row_t;
  typedef trans_row_t [NUM_ACTIONS-1:0] trans_tbl_t;
  typedef prob_t [1:0]       obs_row_t;
  typedef obs_row_t [NUM_ACTIONS-1:0]   obs_tbl_t;

endpackage

// File: rtl/frac_div.sv
// Restoring fractional divider: quot = floor((a << W) / b), one bit per cycle, needs a < b.
module frac_div #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W:0]   b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot
);

  localparam int CW = $clog2(W + 1);

  logic [W:0]    rem_reg, rem_next;
  logic [W:0]    b_reg;
  logic [W-1:0]  quot_reg, quot_next;
  logic [CW-1:0] cnt_reg;
  logic [W+1:0]  trial;
  logic [W:0]    diff;
  logic          fits;

  // rem < b always holds, so the doubled remainder minus b fits in W+1 bits
  assign trial     = {rem_reg, 1'b0};
  assign fits      = trial >= {1'b0, b_reg};
  assign diff      = trial[W:0] - b_reg;
  assign rem_next  = fits ? diff : trial[W:0];
  assign quot_next = {quot_reg[W-2:0], fits};

  assign busy = cnt_reg != '0;
  // done marks the cycle whose edge produces the last quotient bit; quot is valid then
  assign done = busy && (cnt_reg == CW'(1));
  assign quot = quot_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg  <= '0;
      b_reg    <= '0;
      quot_reg <= '0;
      cnt_reg  <= '0;
    end else if (start) begin
      rem_reg  <= {1'b0, a};
      b_reg    <= b;
      quot_reg <= '0;
      cnt_reg  <= CW'(W);
    end else if (busy) begin
      rem_reg  <= rem_next;
      quot_reg <= quot_next;
      cnt_reg  <= cnt_reg - CW'(1);
    end
  end

endmodule

// File: rtl/belief_update.sv
// Bayesian belief update for the 2-state POMDP: predict, correct, normalise -> posterior b'(s'=0).
module belief_update
  import pomdp_pkg::*;
#(
  parameter int PW      = PROB_W,
  parameter int NUM_ACT = NUM_ACTIONS
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [1:0]                             action,
  input  logic                                   obs,
  input  logic [PW-1:0]                          belief_in,
  input  logic [NUM_ACT-1:0][1:0][1:0][PW-1:0]   trans,
  input  logic [NUM_ACT-1:0][1:0][PW-1:0]        obs_prob,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [PW-1:0]                          belief_out,
  output logic                                   err
);

  localparam logic [PW-1:0] ONE = '1;

  bu_state_e     state_reg, state_next;
  logic          act_bad_reg, obs_reg, err_reg;
  logic [PW-1:0] b0_reg, t0_reg, t1_reg, op0_reg, op1_reg;
  logic [PW-1:0] pred0_reg, u0_reg, u1_reg, belief_reg;
  logic [PW:0]   sum_reg;

  logic            act_ok, degenerate, saturate;
  logic [2*PW-1:0] mix_acc, m0, m1;
  logic [PW-1:0]   pred0_next, o0, o1, u0_next, u1_next;
  logic            div_start, div_done, div_busy_unused;
  logic [PW-1:0]   div_quot;

  // Only column [0] of each trans row carries information; fold the rest away.
  logic [2*NUM_ACT-1:0] unused_trans_bits;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ACT; gi++) begin : g_unused
      assign unused_trans_bits[2*gi]   = ^trans[gi][0][1];
      assign unused_trans_bits[2*gi+1] = ^trans[gi][1][1];
    end
  endgenerate

  assign act_ok = 32'(action) < NUM_ACT;

  // Weights sum to ONE, so the mixed product never exceeds ONE*ONE and needs no carry bit.
  assign mix_acc    = (2*PW)'(b0_reg) * (2*PW)'(t0_reg)
                    + (2*PW)'(ONE - b0_reg) * (2*PW)'(t1_reg);
  assign pred0_next = PW'(mix_acc >> PW);

  assign o0      = obs_reg ? (ONE - op0_reg) : op0_reg;
  assign o1      = obs_reg ? (ONE - op1_reg) : op1_reg;
  assign m0      = (2*PW)'(pred0_reg) * (2*PW)'(o0);
  assign m1      = (2*PW)'(ONE - pred0_reg) * (2*PW)'(o1);
  assign u0_next = PW'(m0 >> PW);
  assign u1_next = PW'(m1 >> PW);

  assign degenerate = act_bad_reg || (sum_reg == '0);
  assign saturate   = (u1_reg == '0);

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign belief_out = belief_reg;
  assign err        = err_reg;

  frac_div #(.W(PW)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .a     (u0_reg),
    .b     (sum_reg),
    .busy  (div_busy_unused),
    .done  (div_done),
    .quot  (div_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    div_start  = 1'b0;
    case (state_reg)
      IDLE: if (in_valid) state_next = PRED;
      PRED: state_next = CORR;
      CORR: state_next = NORM;
      NORM: begin
        if (degenerate || saturate) begin
          state_next = DONE;
        end else begin
          div_start  = 1'b1;
          state_next = DIV;
        end
      end
      DIV:  if (div_done) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_bad_reg <= 1'b0;
      obs_reg     <= 1'b0;
      b0_reg      <= '0;
      t0_reg      <= '0;
      t1_reg      <= '0;
      op0_reg     <= '0;
      op1_reg     <= '0;
      pred0_reg   <= '0;
      u0_reg      <= '0;
      u1_reg      <= '0;
      sum_reg     <= '0;
      belief_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            act_bad_reg <= !act_ok;
            obs_reg     <= obs;
            b0_reg      <= belief_in;
            if (act_ok) begin
              t0_reg  <= trans[action][0][0];
              t1_reg  <= trans[action][1][0];
              op0_reg <= obs_prob[action][0];
              op1_reg <= obs_prob[action][1];
            end else begin
              t0_reg  <= '0;
              t1_reg  <= '0;
              op0_reg <= '0;
              op1_reg <= '0;
            end
          end
        end
        PRED: pred0_reg <= pred0_next;
        CORR: begin
          u0_reg  <= u0_next;
          u1_reg  <= u1_next;
          sum_reg <= {1'b0, u0_next} + {1'b0, u1_next};
        end
        NORM: begin
          if (degenerate) begin
            belief_reg <= b0_reg;
            err_reg    <= 1'b1;
          end else if (saturate) begin
            belief_reg <= ONE;
            err_reg    <= 1'b0;
          end
        end
        DIV: begin
          if (div_done) begin
            belief_reg <= div_quot;
            err_reg    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
